// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MIPS memory stage: opcode fields, load/store
// opcodes, store-data forward selects and the pipeline register payloads.
package mem_stage_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned OP_W   = 6;

  // Load/store primary opcodes (IR[31:26])
  localparam logic [OP_W-1:0] OP_LB  = 6'b100000;
  localparam logic [OP_W-1:0] OP_LH  = 6'b100001;
  localparam logic [OP_W-1:0] OP_LW  = 6'b100011;
  localparam logic [OP_W-1:0] OP_LBU = 6'b100100;
  localparam logic [OP_W-1:0] OP_LHU = 6'b100101;
  localparam logic [OP_W-1:0] OP_SB  = 6'b101000;
  localparam logic [OP_W-1:0] OP_SH  = 6'b101001;
  localparam logic [OP_W-1:0] OP_SW  = 6'b101011;

  // Store-data forward selects
  localparam logic [1:0] FWD_RT_REG     = 2'd0;
  localparam logic [1:0] FWD_WDATA      = 2'd1;
  localparam logic [1:0] FWD_PC8_W      = 2'd2;
  localparam logic [1:0] FWD_RT_REG_ALT = 2'd3;

  // EX/MEM register payload
  typedef struct packed {
    logic [WORD_W-1:0] ir;
    logic [WORD_W-1:0] pc8;
    logic [WORD_W-1:0] aluout;
    logic [WORD_W-1:0] rt;
  } ex_mem_t;

  // MEM/WB register payload
  typedef struct packed {
    logic [WORD_W-1:0] ir;
    logic [WORD_W-1:0] pc8;
    logic [WORD_W-1:0] aluout;
    logic [WORD_W-1:0] dmout;
  } mem_wb_t;

  function automatic logic is_load(input logic [OP_W-1:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_store(input logic [OP_W-1:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_word(input logic [OP_W-1:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic is_half(input logic [OP_W-1:0] op);
    return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
  endfunction

endpackage

// File: rtl/mem_stage_load_ext.sv
// Load data lane select and sign/zero extension for the memory stage.
module mem_stage_load_ext
  import mem_stage_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [1:0]        lane,
  input  logic [OP_W-1:0]   op,
  output logic [WORD_W-1:0] data
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  // Pick the addressed half/byte (little-endian) and extend per opcode
  always_comb begin
    half_sel = lane[1] ? word[31:16] : word[15:0];
    case (lane)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    data = '0;
    case (op)
      OP_LW:   data = word;
      OP_LH:   data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  data = {16'h0000, half_sel};
      OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  data = {24'h000000, byte_sel};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: EX/MEM register, data memory with byte/half/word
// access, MEM/WB register and M-stage forwarding sources.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DM_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] IR_M,
  input  logic [WORD_W-1:0] PC8_M,
  input  logic [WORD_W-1:0] ALUOUT_M,
  input  logic [WORD_W-1:0] RT_M,
  input  logic [1:0]        Forward_RT_M,
  input  logic [WORD_W-1:0] mux_Wdata_out,
  input  logic [WORD_W-1:0] PC8_W_out,
  output logic [WORD_W-1:0] ALUOUT_M_out,
  output logic [WORD_W-1:0] PC8_M_out,
  output logic [WORD_W-1:0] IR_M_out,
  output logic              addr_err_M,
  output logic [WORD_W-1:0] IR_W,
  output logic [WORD_W-1:0] PC8_W,
  output logic [WORD_W-1:0] ALUOUT_W,
  output logic [WORD_W-1:0] DMOUT_W
);

  localparam int unsigned      IDX_W      = $clog2(DM_WORDS);
  localparam logic [WORD_W-1:0] ADDR_LIMIT = WORD_W'(4 * DM_WORDS);

  ex_mem_t m_q;
  mem_wb_t w_q;

  logic [WORD_W-1:0] dmem [DM_WORDS];

  logic [OP_W-1:0]   op;
  logic [WORD_W-1:0] addr;
  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] rd_word;
  logic [WORD_W-1:0] sd;
  logic [WORD_W-1:0] wr_word;
  logic [WORD_W-1:0] ext_data;
  logic              err;
  logic              we;

  assign op      = m_q.ir[31:26];
  assign addr    = m_q.aluout;
  assign idx     = addr[IDX_W+1:2];
  assign rd_word = dmem[idx];

  // Alignment and range check for the load/store currently in M
  always_comb begin
    err = 1'b0;
    if (is_load(op) || is_store(op)) begin
      if (is_word(op) && (addr[1:0] != 2'b00)) err = 1'b1;
      if (is_half(op) && addr[0])              err = 1'b1;
      if (addr >= ADDR_LIMIT)                  err = 1'b1;
    end
  end

  assign addr_err_M = err;

  // Store data select; codes 0 and 3 both take the registered rt
  always_comb begin
    sd = m_q.rt;
    case (Forward_RT_M)
      FWD_WDATA:                  sd = mux_Wdata_out;
      FWD_PC8_W:                  sd = PC8_W_out;
      FWD_RT_REG, FWD_RT_REG_ALT: sd = m_q.rt;
      default:                    sd = m_q.rt;
    endcase
  end

  // Merge store data into the addressed lanes, preserving the others
  always_comb begin
    wr_word = rd_word;
    case (op)
      OP_SW: wr_word = sd;
      OP_SH: begin
        if (addr[1]) wr_word[31:16] = sd[15:0];
        else         wr_word[15:0]  = sd[15:0];
      end
      OP_SB: begin
        case (addr[1:0])
          2'd0:    wr_word[7:0]   = sd[7:0];
          2'd1:    wr_word[15:8]  = sd[7:0];
          2'd2:    wr_word[23:16] = sd[7:0];
          default: wr_word[31:24] = sd[7:0];
        endcase
      end
      default: wr_word = rd_word;
    endcase
  end

  assign we = is_store(op) && !err;

  mem_stage_load_ext u_load_ext (
    .word (rd_word),
    .lane (addr[1:0]),
    .op   (op),
    .data (ext_data)
  );

  // Data memory: cleared on reset, written at the edge ending the store's M cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DM_WORDS; i++) dmem[i] <= '0;
    end else if (we) begin
      dmem[idx] <= wr_word;
    end
  end

  // EX/MEM and MEM/WB pipeline registers
  always_ff @(posedge clk) begin
    if (reset) begin
      m_q <= '0;
      w_q <= '0;
    end else begin
      m_q.ir     <= IR_M;
      m_q.pc8    <= PC8_M;
      m_q.aluout <= ALUOUT_M;
      m_q.rt     <= RT_M;
      w_q.ir     <= m_q.ir;
      w_q.pc8    <= m_q.pc8;
      w_q.aluout <= m_q.aluout;
      w_q.dmout  <= (is_load(op) && !err) ? ext_data : '0;
    end
  end

  assign ALUOUT_M_out = m_q.aluout;
  assign PC8_M_out    = m_q.pc8;
  assign IR_M_out     = m_q.ir;
  assign IR_W         = w_q.ir;
  assign PC8_W        = w_q.pc8;
  assign ALUOUT_W     = w_q.aluout;
  assign DMOUT_W      = w_q.dmout;

endmodule

// File: tb/tb_mem_stage.sv
// Directed, table-driven bench for mem_stage with hand-computed expectations.
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic [31:0] IR_M, PC8_M, ALUOUT_M, RT_M;
  logic [1:0]  Forward_RT_M;
  logic [31:0] mux_Wdata_out, PC8_W_out;
  logic [31:0] ALUOUT_M_out, PC8_M_out, IR_M_out;
  logic        addr_err_M;
  logic [31:0] IR_W, PC8_W, ALUOUT_W, DMOUT_W;

  int n_cmp = 0;
  int n_bad = 0;

  mem_stage #(.DM_WORDS(1024)) dut (
    .clk           (clk),
    .reset         (reset),
    .IR_M          (IR_M),
    .PC8_M         (PC8_M),
    .ALUOUT_M      (ALUOUT_M),
    .RT_M          (RT_M),
    .Forward_RT_M  (Forward_RT_M),
    .mux_Wdata_out (mux_Wdata_out),
    .PC8_W_out     (PC8_W_out),
    .ALUOUT_M_out  (ALUOUT_M_out),
    .PC8_M_out     (PC8_M_out),
    .IR_M_out      (IR_M_out),
    .addr_err_M    (addr_err_M),
    .IR_W          (IR_W),
    .PC8_W         (PC8_W),
    .ALUOUT_W      (ALUOUT_W),
    .DMOUT_W       (DMOUT_W)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [5:0] LB = 6'b100000, LH = 6'b100001, LW = 6'b100011,
                         LBU = 6'b100100, LHU = 6'b100101,
                         SB = 6'b101000, SH = 6'b101001, SW = 6'b101011,
                         ADDU = 6'b000000;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] rt;
    logic [1:0]  fwd;
    logic [31:0] wdata;
    logic [31:0] pc8w;
    logic        exp_err;
    logic [31:0] exp_dm;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] mk_ir(input logic [5:0] op);
    return {op, 26'h0123456};
  endfunction

  task automatic add(input logic [5:0] op, input logic [31:0] addr,
                     input logic [31:0] rt, input logic [1:0] fwd,
                     input logic [31:0] wdata, input logic [31:0] pc8w,
                     input logic exp_err, input logic [31:0] exp_dm);
    vec_t v;
    v.op = op; v.addr = addr; v.rt = rt; v.fwd = fwd; v.wdata = wdata;
    v.pc8w = pc8w; v.exp_err = exp_err; v.exp_dm = exp_dm;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ir, input logic [31:0] pc8,
                       input logic [31:0] alu, input logic [31:0] rt);
    IR_M = ir; PC8_M = pc8; ALUOUT_M = alu; RT_M = rt;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ALUOUT_M_out"}, ALUOUT_M_out, 32'h0);
    check({tag, " PC8_M_out"},    PC8_M_out,    32'h0);
    check({tag, " IR_M_out"},     IR_M_out,     32'h0);
    check({tag, " addr_err_M"},   {31'h0, addr_err_M}, 32'h0);
    check({tag, " IR_W"},         IR_W,         32'h0);
    check({tag, " PC8_W"},        PC8_W,        32'h0);
    check({tag, " ALUOUT_W"},     ALUOUT_W,     32'h0);
    check({tag, " DMOUT_W"},      DMOUT_W,      32'h0);
  endtask

  initial begin
    reset = 1'b1;
    drive(32'h0, 32'h0, 32'h0, 32'h0);
    Forward_RT_M = 2'd0; mux_Wdata_out = 32'h0; PC8_W_out = 32'h0;

    // Vector table: memory state carries from one row to the next
    add(SW,  32'h20,   32'h80FF7F01, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    add(LB,  32'h20,   32'h0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h00000001);
    add(LB,  32'h23,   32'h0, 2'd0, 32'h0, 32'h0, 1'b0, 32'hFFFFFF80);
    add(LBU, 32'h23,   32'h0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h00000080);
    add(LH,  32'h22,   32'h0, 2'd0, 32'h0, 32'h0, 1'b0, 32'hFFFF80FF);
    add(LHU, 32'h22,   32'h0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h000080FF);
    add(SW,  32'h30,   32'h11223344, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    add(SB,  32'h31,   32'h555555AA, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    add(LW,  32'h30,   32'h0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h1122AA44);
    add(SH,  32'h32,   32'h7777BBCC, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    add(LW,  32'h30,   32'h0, 2'd0, 32'h0, 32'h0, 1'b0, 32'hBBCCAA44);
    add(SW,  32'h40,   32'hCAFEF00D, 2'd1, 32'h12345678, 32'h0, 1'b0, 32'h0);
    add(LW,  32'h40,   32'h0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h12345678);
    add(SW,  32'h41,   32'hFFFFFFFF, 2'd0, 32'h0, 32'h0, 1'b1, 32'h0);
    add(LW,  32'h40,   32'h0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h12345678);
    add(LH,  32'h4001, 32'h0, 2'd0, 32'h0, 32'h0, 1'b1, 32'h0);
    add(SW,  32'h1000, 32'hBAD0BAD0, 2'd0, 32'h0, 32'h0, 1'b1, 32'h0);
    add(LW,  32'h0,    32'h0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    add(SW,  32'h50,   32'h0, 2'd2, 32'hEEEEEEEE, 32'h00ABCDEF, 1'b0, 32'h0);
    add(LW,  32'h50,   32'h0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h00ABCDEF);
    add(SW,  32'h60,   32'h13579BDF, 2'd3, 32'hEEEEEEEE, 32'hDDDDDDDD, 1'b0, 32'h0);
    add(LW,  32'h60,   32'h0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h13579BDF);
    add(LW,  32'h6,    32'h0, 2'd0, 32'h0, 32'h0, 1'b1, 32'h0);
    add(LH,  32'h6,    32'h0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    add(ADDU,32'h33,   32'h0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    add(SB,  32'hFFF,  32'h1234569C, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    add(LBU, 32'hFFF,  32'h0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0000009C);
    add(LB,  32'hFFF,  32'h0, 2'd0, 32'h0, 32'h0, 1'b0, 32'hFFFFFF9C);
    add(LW,  32'hFFC,  32'h0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h9C000000);

    // Reset state
    step(); step();
    check_all_zero("reset");
    reset = 1'b0;

    // sw then lw of the same word on the next cycle
    drive(mk_ir(SW), 32'h00400008, 32'h10, 32'hDEADBEEF);
    step();
    check("b2b ALUOUT_M_out", ALUOUT_M_out, 32'h10);
    check("b2b PC8_M_out",    PC8_M_out,    32'h00400008);
    check("b2b IR_M_out",     IR_M_out,     mk_ir(SW));
    check("b2b sw err",       {31'h0, addr_err_M}, 32'h0);
    drive(mk_ir(LW), 32'h0040000C, 32'h10, 32'h0);
    step();
    check("b2b IR_W sw",      IR_W,    mk_ir(SW));
    check("b2b PC8_W sw",     PC8_W,   32'h00400008);
    check("b2b DMOUT_W sw",   DMOUT_W, 32'h0);
    check("b2b IR_M_out lw",  IR_M_out, mk_ir(LW));
    drive(32'h0, 32'h0, 32'h0, 32'h0);
    step();
    check("b2b DMOUT_W lw",   DMOUT_W, 32'hDEADBEEF);
    check("b2b ALUOUT_W lw",  ALUOUT_W, 32'h10);

    // Table: one instruction at a time followed by a nop bubble
    for (int i = 0; i < vecs.size(); i++) begin
      logic [31:0] pc;
      string tag;
      pc  = 32'h00401000 + 32'(8 * i);
      tag = $sformatf("v%0d", i);
      Forward_RT_M  = vecs[i].fwd;
      mux_Wdata_out = vecs[i].wdata;
      PC8_W_out     = vecs[i].pc8w;
      drive(mk_ir(vecs[i].op), pc, vecs[i].addr, vecs[i].rt);
      step();
      check({tag, " IR_M_out"},     IR_M_out,     mk_ir(vecs[i].op));
      check({tag, " ALUOUT_M_out"}, ALUOUT_M_out, vecs[i].addr);
      check({tag, " addr_err_M"},   {31'h0, addr_err_M}, {31'h0, vecs[i].exp_err});
      drive(32'h0, 32'h0, 32'h0, 32'h0);
      step();
      check({tag, " IR_W"},     IR_W,     mk_ir(vecs[i].op));
      check({tag, " PC8_W"},    PC8_W,    pc);
      check({tag, " ALUOUT_W"}, ALUOUT_W, vecs[i].addr);
      check({tag, " DMOUT_W"},  DMOUT_W,  vecs[i].exp_dm);
    end
    Forward_RT_M = 2'd0; mux_Wdata_out = 32'h0; PC8_W_out = 32'h0;

    // Reset while a sw sits in M: store suppressed, memory cleared
    drive(mk_ir(SW), 32'h00402000, 32'h70, 32'h55AA55AA);
    step();
    check("rst sw in M", IR_M_out, mk_ir(SW));
    drive(32'h0, 32'h0, 32'h0, 32'h0);
    reset = 1'b1;
    step();
    check_all_zero("rst");
    reset = 1'b0;
    drive(mk_ir(LW), 32'h00402008, 32'h70, 32'h0);
    step();
    drive(mk_ir(LW), 32'h00402010, 32'h20, 32'h0);
    step();
    check("rst lw 0x70", DMOUT_W, 32'h0);
    drive(32'h0, 32'h0, 32'h0, 32'h0);
    step();
    check("rst lw 0x20", DMOUT_W, 32'h0);
    check("rst lw 0x20 ALUOUT_W", ALUOUT_W, 32'h20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
